alu_div_seq: RTL and testbench

- Multi-cycle iterative divider that sequences one shared 32-bit subtract/compare datapath. It implements RISC-V M-extension DIV, DIVU, REM and REMU.
- Sits beside the single-cycle ALU. The control unit starts it and stalls the PC while o_busy is high. The result is written back on o_valid.
- Uses restoring division: one quotient bit per cycle, driven by the carry-out of an A + ~B + 1 subtraction.

---
 rtl/div_pkg.sv | 6 +
 rtl/div_step.sv | 18 +
 rtl/alu_div_seq.sv | 78 +++++++
 tb/tb_alu_div_seq.sv | 122 ++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared width, FSM state type and divide-by-zero quotient constant for the iterative divider.
package div_pkg;
  localparam int XLEN_DEF = 32;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_e;
  localparam logic [XLEN_DEF-1:0] DIV0_QUOT = '1;
endpackage

// File: rtl/div_step.sv
// div_step: one restoring-division step; the quotient bit is the carry-out of rem_shifted + ~divisor + 1.
module div_step
  import div_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [XLEN:0]   i_rem_shifted,
  input  logic [XLEN-1:0] i_divisor,
  output logic [XLEN-1:0] o_next_rem,
  output logic            o_q_bit
);
  logic [XLEN-1:0] w_diff;
  logic            w_carry;
  // The divisor's 33rd bit is zero, so the widened carry reduces to the top bit OR the 32-bit carry.
  assign {w_carry, w_diff} = {1'b0, i_rem_shifted[XLEN-1:0]} + {1'b0, ~i_divisor} + (XLEN+1)'(1);
  assign o_q_bit    = i_rem_shifted[XLEN] | w_carry;
  assign o_next_rem = o_q_bit ? w_diff : i_rem_shifted[XLEN-1:0];
endmodule

// File: rtl/alu_div_seq.sv
// alu_div_seq: multi-cycle restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
module alu_div_seq
  import div_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic            i_flush,
  input  logic            i_signed,
  input  logic [XLEN-1:0] i_dividend,
  input  logic [XLEN-1:0] i_divisor,
  output logic            o_busy,
  output logic            o_valid,
  output logic [XLEN-1:0] o_quotient,
  output logic [XLEN-1:0] o_remainder
);
  localparam int CW = $clog2(XLEN);
  div_state_e      r_state, w_next;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_q, r_rem, r_b, w_next_rem, w_a_mag, w_b_mag;
  logic            r_neg_q, r_neg_r, w_q_bit, w_accept, w_div0, w_a_neg, w_b_neg;
  assign w_a_neg  = i_signed & i_dividend[XLEN-1];
  assign w_b_neg  = i_signed & i_divisor[XLEN-1];
  assign w_a_mag  = w_a_neg ? -i_dividend : i_dividend;
  assign w_b_mag  = w_b_neg ? -i_divisor : i_divisor;
  assign w_accept = (r_state == IDLE) & i_start & ~i_flush;
  assign w_div0   = i_divisor == '0;
  assign o_busy   = (r_state != IDLE) | o_valid;
  // r_q starts as the dividend magnitude and shifts quotient bits in as dividend bits shift out.
  div_step #(.XLEN(XLEN)) u_step (
    .i_rem_shifted({r_rem, r_q[XLEN-1]}),
    .i_divisor    (r_b),
    .o_next_rem   (w_next_rem),
    .o_q_bit      (w_q_bit)
  );
  always_comb begin
    w_next = IDLE;
    if (r_state == IDLE)
      w_next = !w_accept ? IDLE : (w_div0 ? DONE : BUSY);
    else if (r_state == BUSY)
      w_next = i_flush ? IDLE : (r_cnt == '0 ? DONE : BUSY);
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_q         <= '0;
      r_rem       <= '0;
      r_b         <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      o_valid     <= 1'b0;
      o_quotient  <= '0;
      o_remainder <= '0;
    end else begin
      r_state <= w_next;
      o_valid <= (r_state == DONE) & ~i_flush;
      if (w_accept) begin
        r_cnt   <= CW'(XLEN-1);
        r_b     <= w_b_mag;
        // Divide by zero preloads the architectural result so DONE needs no special case.
        r_q     <= w_div0 ? DIV0_QUOT : w_a_mag;
        r_rem   <= w_div0 ? i_dividend : '0;
        r_neg_q <= ~w_div0 & (w_a_neg ^ w_b_neg);
        r_neg_r <= ~w_div0 & w_a_neg;
      end else if (r_state == BUSY && !i_flush) begin
        r_rem <= w_next_rem;
        r_q   <= {r_q[XLEN-2:0], w_q_bit};
        r_cnt <= r_cnt - 1'b1;
      end else if (r_state == DONE && !i_flush) begin
        o_quotient  <= r_neg_q ? -r_q : r_q;
        o_remainder <= r_neg_r ? -r_rem : r_rem;
      end
    end
  end
endmodule

// File: tb/tb_alu_div_seq.sv
// tb_alu_div_seq: directed checks of results, latency, flush, reset and ignored restarts.
module tb_alu_div_seq;
  logic        clk = 1'b0;
  logic        rst, start, flush, sgn;
  logic [31:0] dvd, dvs, quo, rem;
  logic        busy, valid;
  int          checks = 0;
  int          failures = 0;
  always #5 clk = ~clk;
  alu_div_seq dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_flush(flush), .i_signed(sgn),
    .i_dividend(dvd), .i_divisor(dvs), .o_busy(busy), .o_valid(valid),
    .o_quotient(quo), .o_remainder(rem)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [31:0] eq, input logic [31:0] er, input int elat);
    int   lat;
    logic busy_ok;
    @(negedge clk);
    start = 1'b1; dvd = a; dvs = b; sgn = s;
    @(negedge clk);
    start = 1'b0;
    lat = 0; busy_ok = 1'b1;
    while (!valid && lat < 40) begin
      busy_ok &= busy;
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, lat, elat);
    chk({tag, "_busy"}, {31'b0, busy_ok & busy}, 1);
    chk({tag, "_q"}, quo, eq);
    chk({tag, "_r"}, rem, er);
    @(negedge clk);
    chk({tag, "_idle"}, {30'b0, busy, valid}, 0);
  endtask
  initial begin
    int   lat;
    logic busy_ok, seen;
    rst = 1'b1; start = 1'b0; flush = 1'b0; sgn = 1'b0; dvd = '0; dvs = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_q", quo, 0);
    chk("rst_r", rem, 0);
    chk("rst_flags", {30'b0, busy, valid}, 0);
    do_div("u100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 33);
    do_div("u8000_7fff", 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 32'd1, 32'd1, 33);
    do_div("uffff_7fff", 32'hFFFF_FFFF, 32'h7FFF_FFFF, 1'b0, 32'd2, 32'd1, 33);
    do_div("uffff_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 33);
    do_div("ufff9_2", 32'hFFFF_FFF9, 32'd2, 1'b0, 32'h7FFF_FFFC, 32'd1, 33);
    do_div("sm7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
    do_div("s7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 33);
    do_div("sm100_m7", 32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 32'd14, 32'hFFFF_FFFE, 33);
    do_div("sovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 33);
    do_div("u_div0", 32'h1234_5678, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678, 1);
    do_div("s_div0", 32'h1234_5678, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'h1234_5678, 1);
    // flush at BUSY cycle 10: no result, previous outputs retained
    @(negedge clk);
    start = 1'b1; dvd = 32'd100; dvs = 32'd7; sgn = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_idle", {30'b0, busy, valid}, 0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      seen |= valid;
    end
    chk("flush_novalid", {31'b0, seen}, 0);
    chk("flush_keep_q", quo, 32'hFFFF_FFFF);
    chk("flush_keep_r", rem, 32'h1234_5678);
    // start together with flush in IDLE is dropped
    start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("flush_start_drop", {30'b0, busy, valid}, 0);
    // a second start while busy is ignored
    start = 1'b1; dvd = 32'd100; dvs = 32'd7; sgn = 1'b0;
    @(negedge clk);
    start = 1'b0;
    lat = 0; busy_ok = 1'b1;
    while (!valid && lat < 40) begin
      if (lat == 4) begin
        start = 1'b1; dvd = 32'd9; dvs = 32'd3;
      end else
        start = 1'b0;
      busy_ok &= busy;
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    chk("restart_lat", lat, 33);
    chk("restart_busy", {31'b0, busy_ok}, 1);
    chk("restart_q", quo, 32'd14);
    chk("restart_r", rem, 32'd2);
    @(negedge clk);
    chk("restart_idle", {30'b0, busy, valid}, 0);
    // reset mid-operation clears everything
    start = 1'b1; dvd = 32'd500; dvs = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_q", quo, 0);
    chk("midrst_r", rem, 0);
    chk("midrst_flags", {30'b0, busy, valid}, 0);
    do_div("post_rst", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 33);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
